// File: rtl/serial_dot_acc_pkg.sv
// Shared constants and state encoding for the serial dot-product accumulator.
package serial_dot_acc_pkg;
  localparam int FRAME_DEF = 16;
  localparam int ACCW_DEF  = 24;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/serial_dot_acc_if.sv
// Serial product input, frame length and result handshake of serial_dot_acc.
interface serial_dot_acc_if #(
  parameter int ACCW = 24
);
  logic            qs;
  logic            sync;
  logic [7:0]      len;
  logic [ACCW-1:0] acc_out;
  logic            out_valid;
  logic            out_ready;
  logic            overrun;
  logic            sync_err;

  modport master (
    output qs, sync, len, out_ready,
    input  acc_out, out_valid, overrun, sync_err
  );

  modport slave (
    input  qs, sync, len, out_ready,
    output acc_out, out_valid, overrun, sync_err
  );
endinterface

// File: rtl/serial_deser.sv
// Bit indexing and frame capture: turns an LSB-first serial product into a
// parallel word with a one-cycle done strobe in the cycle of its last bit.
module serial_deser
  import serial_dot_acc_pkg::*;
#(
  parameter int FRAME = FRAME_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             qs,
  input  logic             sync,
  output logic [FRAME-1:0] prod,
  output logic             prod_done,
  output logic             frame_start,
  output logic             frame_err
);
  localparam int IW = $clog2(FRAME);

  state_t          state, state_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic [FRAME-2:0] bits_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Bits enter at the top and walk down, so bit 0 ends up at bits_p0[0].
  always_ff @(posedge clk) begin
    if (state == SHIFT || sync)
      bits_p0 <= {qs, bits_p0[FRAME-2:1]};
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    prod_done   = 1'b0;
    frame_start = 1'b0;
    frame_err   = 1'b0;
    case (state)
      IDLE: begin
        if (sync) begin
          frame_start = 1'b1;
          state_nx    = SHIFT;
          idx_nx      = IW'(1);
        end
      end
      SHIFT: begin
        // A sync here is always mid-frame; restart takes priority over completion.
        if (sync) begin
          frame_start = 1'b1;
          frame_err   = 1'b1;
          idx_nx      = IW'(1);
        end else if (idx == IW'(FRAME - 1)) begin
          prod_done = 1'b1;
          state_nx  = IDLE;
          idx_nx    = '0;
        end else begin
          idx_nx = idx + IW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign prod = {qs, bits_p0};
endmodule

// File: rtl/serial_dot_acc.sv
// Accumulates serial products into groups of len frames and hands each sum
// to a valid/ready consumer, flagging overruns and mid-frame syncs.
module serial_dot_acc
  import serial_dot_acc_pkg::*;
#(
  parameter int FRAME = FRAME_DEF,
  parameter int ACCW  = ACCW_DEF
) (
  input logic               clk,
  input logic               rst,
  serial_dot_acc_if.slave   bus
);
  logic [FRAME-1:0] prod;
  logic             prod_done, frame_start, frame_err;
  logic [8:0]       cnt, len_grp;
  logic [ACCW-1:0]  acc, sum, res;
  logic             res_vld, ovr, serr, last;

  serial_deser #(.FRAME(FRAME)) u_deser (
    .clk         (clk),
    .rst         (rst),
    .qs          (bus.qs),
    .sync        (bus.sync),
    .prod        (prod),
    .prod_done   (prod_done),
    .frame_start (frame_start),
    .frame_err   (frame_err)
  );

  assign sum  = acc + ACCW'(prod);
  assign last = (cnt + 9'd1) == len_grp;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      len_grp <= 9'd256;
      acc     <= '0;
      res     <= '0;
      res_vld <= 1'b0;
      ovr     <= 1'b0;
      serr    <= 1'b0;
    end else begin
      // len is latched only when the first frame of a group starts.
      if (frame_start && cnt == 9'd0)
        len_grp <= (bus.len == 8'd0) ? 9'd256 : {1'b0, bus.len};
      if (frame_err)
        serr <= 1'b1;
      if (prod_done) begin
        if (last) begin
          cnt <= '0;
          acc <= '0;
        end else begin
          cnt <= cnt + 9'd1;
          acc <= sum;
        end
      end
      // A load on the same edge as a handshake replaces the result cleanly.
      if (prod_done && last) begin
        res     <= sum;
        res_vld <= 1'b1;
        if (res_vld && !bus.out_ready)
          ovr <= 1'b1;
      end else if (res_vld && bus.out_ready) begin
        res_vld <= 1'b0;
      end
    end
  end

  assign bus.acc_out   = res;
  assign bus.out_valid = res_vld;
  assign bus.overrun   = ovr;
  assign bus.sync_err  = serr;
endmodule

// File: tb/tb_serial_dot_acc.sv
// Self-checking bench for serial_dot_acc: directed scenarios plus randomized
// groups checked against a sum-of-frames reference model.
module tb_serial_dot_acc;
  logic clk;
  logic rst;

  serial_dot_acc_if #(.ACCW(24)) bus ();

  serial_dot_acc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          vld_cycles = 0;
  int          results_seen = 0;
  logic [23:0] last_res = '0;
  logic        pre_valid = 1'b0;
  bit          mon_en = 1'b0;
  logic [23:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: returns at the falling edge, where outputs are sampled.
  task automatic step();
    logic [23:0] e;
    @(negedge clk);
    if (bus.out_valid === 1'b1) begin
      vld_cycles++;
      last_res = bus.acc_out;
    end
    if (mon_en && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      chk("res_pending", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rand_result", 32'(bus.acc_out), 32'(e));
        results_seen++;
      end
    end
  endtask

  task automatic send_frame(input logic [15:0] v);
    for (int k = 0; k < 16; k++) begin
      bus.sync = (k == 0);
      bus.qs   = v[k];
      if (k == 15) pre_valid = bus.out_valid;
      step();
    end
    bus.sync = 1'b0;
    bus.qs   = 1'b0;
  endtask

  task automatic partial(input logic [15:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      bus.sync = (k == 0);
      bus.qs   = v[k];
      step();
    end
  endtask

  task automatic do_rst();
    rst      = 1'b1;
    bus.sync = 1'b0;
    bus.qs   = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_acc"},  32'(bus.acc_out),   32'd0);
    chk({tag, "_vld"},  32'(bus.out_valid), 32'd0);
    chk({tag, "_ovr"},  32'(bus.overrun),   32'd0);
    chk({tag, "_serr"}, 32'(bus.sync_err),  32'd0);
  endtask

  initial begin
    logic [15:0] vals[8];
    logic [23:0] gsum;
    int          glen;
    bit          saw_err;

    rst           = 1'b1;
    bus.qs        = 1'b0;
    bus.sync      = 1'b1;
    bus.len       = 8'd1;
    bus.out_ready = 1'b0;
    step();
    step();
    chk_idle_outputs("reset");
    rst      = 1'b0;
    bus.sync = 1'b0;

    // Single frame, latency of FRAME cycles from sync.
    bus.len = 8'd1;
    send_frame(16'h000F);
    chk("t1_pre_valid", 32'(pre_valid), 32'd0);
    chk("t1_acc", 32'(bus.acc_out), 32'd15);
    chk("t1_vld", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    step();
    chk("t1_vld_drop", 32'(bus.out_valid), 32'd0);

    // Three back-to-back frames, one result.
    bus.len    = 8'd3;
    vld_cycles = 0;
    send_frame(16'hFFFF);
    send_frame(16'hFFFF);
    send_frame(16'h0002);
    repeat (3) step();
    chk("t2_pulses", 32'(vld_cycles), 32'd1);
    chk("t2_acc", 32'(last_res), 32'h020000);

    // len=0 means 256 frames.
    bus.len    = 8'd0;
    vld_cycles = 0;
    for (int i = 0; i < 256; i++) begin
      send_frame(16'hFFFF);
      if (i == 0) bus.len = 8'd7;
    end
    repeat (3) step();
    chk("t3_pulses", 32'(vld_cycles), 32'd1);
    chk("t3_acc", 32'(last_res), 32'hFFFF00);

    // Overrun with consumer stalled.
    do_rst();
    bus.len       = 8'd1;
    bus.out_ready = 1'b0;
    send_frame(16'd5);
    chk("t4_first", 32'(bus.acc_out), 32'd5);
    chk("t4_no_ovr", 32'(bus.overrun), 32'd0);
    send_frame(16'd7);
    chk("t4_acc", 32'(bus.acc_out), 32'd7);
    chk("t4_ovr", 32'(bus.overrun), 32'd1);
    repeat (3) step();
    chk("t4_hold_vld", 32'(bus.out_valid), 32'd1);
    chk("t4_hold_acc", 32'(bus.acc_out), 32'd7);
    bus.out_ready = 1'b1;
    step();
    chk("t4_vld_drop", 32'(bus.out_valid), 32'd0);
    chk("t4_ovr_sticky", 32'(bus.overrun), 32'd1);

    // Mid-frame sync at index 5.
    do_rst();
    bus.len = 8'd1;
    partial(16'hFFFF, 5);
    send_frame(16'd9);
    chk("t5_serr", 32'(bus.sync_err), 32'd1);
    chk("t5_acc", 32'(bus.acc_out), 32'd9);
    chk("t5_vld", 32'(bus.out_valid), 32'd1);

    // Reset in the middle of a group, with sync asserted alongside.
    do_rst();
    bus.len = 8'd2;
    send_frame(16'd100);
    partial(16'hABCD, 8);
    rst      = 1'b1;
    bus.sync = 1'b1;
    bus.qs   = 1'b1;
    step();
    chk_idle_outputs("t6_in_rst");
    rst      = 1'b0;
    bus.sync = 1'b0;
    bus.qs   = 1'b0;
    step();
    chk_idle_outputs("t6_after_rst");
    send_frame(16'd1);
    chk_idle_outputs("t6_mid_group");
    send_frame(16'd2);
    chk("t6_acc", 32'(bus.acc_out), 32'd3);
    chk("t6_vld", 32'(bus.out_valid), 32'd1);
    chk("t6_serr", 32'(bus.sync_err), 32'd0);

    // Randomized groups against the sum-of-frames model.
    do_rst();
    bus.out_ready = 1'b1;
    mon_en        = 1'b1;
    saw_err       = 1'b0;
    results_seen  = 0;
    for (int g = 0; g < 30; g++) begin
      glen = $urandom_range(1, 6);
      gsum = '0;
      for (int f = 0; f < glen; f++) begin
        vals[f] = 16'($urandom);
        gsum    = gsum + 24'(vals[f]);
      end
      exp_q.push_back(gsum);
      bus.len = 8'(glen);
      for (int f = 0; f < glen; f++) begin
        if ($urandom_range(0, 5) == 0) begin
          partial(16'($urandom), $urandom_range(1, 15));
          saw_err = 1'b1;
        end
        send_frame(vals[f]);
        if (f == 0) bus.len = 8'($urandom);
        repeat ($urandom_range(0, 2)) begin
          bus.sync = 1'b0;
          bus.qs   = 1'($urandom);
          step();
        end
        bus.qs = 1'b0;
      end
    end
    repeat (4) step();
    mon_en = 1'b0;
    chk("rand_drain", 32'(exp_q.size()), 32'd0);
    chk("rand_count", 32'(results_seen), 32'd30);
    chk("rand_serr", 32'(bus.sync_err), 32'(saw_err));
    chk("rand_ovr", 32'(bus.overrun), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
